// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants for the accumulator CPU control unit:
//               control-bus bit positions, opcodes and sequencer states.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Control-bus bit positions (one datapath action per bit)
    localparam int CB_PC_TO_MAR  = 0;
    localparam int CB_PC_TO_MBR  = 1;
    localparam int CB_PC_INC     = 2;
    localparam int CB_MBR_TO_PC  = 3;
    localparam int CB_MBR_TO_IR  = 4;
    localparam int CB_MEM_TO_MBR = 5;
    localparam int CB_MBR_TO_BR  = 6;
    localparam int CB_IR_LOAD    = 7;
    localparam int CB_MBR_TO_MAR = 8;
    localparam int CB_MAR_LOAD   = 9;
    localparam int CB_PC_LOAD    = 10;
    localparam int CB_ACC_TO_MBR = 11;
    localparam int CB_MBR_TO_MEM = 12;
    localparam int CB_MR_TO_MBR  = 15;
    localparam int CB_MEM_RD     = 16;
    localparam int CB_MEM_WR     = 17;
    localparam int CB_BR_TO_ACC  = 18;
    localparam int CB_ALU_ADD    = 19;
    localparam int CB_ALU_SUB    = 20;

    // Opcodes as seen in the IR
    localparam int OP_STORE  = 'h01;
    localparam int OP_LOAD   = 'h02;
    localparam int OP_ADD    = 'h03;
    localparam int OP_SUB    = 'h04;
    localparam int OP_JMPGEZ = 'h05;
    localparam int OP_JMP    = 'h06;
    localparam int OP_HALT   = 'h07;

    // Sequencer states
    typedef enum logic [4:0] {
        ST_IDLE  = 5'd0,
        ST_F_PC  = 5'd1,
        ST_F_RD  = 5'd2,
        ST_F_LAT = 5'd3,
        ST_F_IR  = 5'd4,
        ST_F_LD  = 5'd5,
        ST_DEC   = 5'd6,
        ST_S_ACC = 5'd7,
        ST_S_OUT = 5'd8,
        ST_S_WR  = 5'd9,
        ST_X_RD  = 5'd10,
        ST_X_LAT = 5'd11,
        ST_X_BR  = 5'd12,
        ST_X_EX  = 5'd13,
        ST_J_PC  = 5'd14,
        ST_J_LD  = 5'd15,
        ST_ILL   = 5'd16,
        ST_HALT  = 5'd17,
        ST_ERR   = 5'd18
    } state_t;

    // Accumulator update selected by the memory-operand instructions
    typedef enum logic [1:0] {
        ALU_PASS = 2'd0,
        ALU_ADD  = 2'd1,
        ALU_SUB  = 2'd2
    } alu_sel_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_timer
// Description : Counts cycles a memory wait state spends without mem_ready
//               and flags a timeout once WAIT_LIMIT stalled cycles have
//               passed and memory is still not ready.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_mem_ready,
    output logic o_timeout
);

    localparam int                CNT_W   = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0]  C_LIMIT = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] r_count;

    // Stall counter: held at zero outside wait states, saturates at the limit
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (!i_mem_ready && (r_count != C_LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A ready arriving on the limit cycle still wins, so timeout needs !ready
    assign o_timeout = !i_mem_ready && (r_count == C_LIMIT);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sequencer
// Description : Hardwired Moore control unit for the 16-bit accumulator CPU.
//               Sequences fetch/decode/execute, handshakes memory through
//               mem_ready and drives the shared datapath control word.
//               All outputs are registered from the next state so they are
//               stable for the whole cycle spent in a state.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CTRL_W     = 32,
    parameter int OPCODE_W   = 8,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [OPCODE_W-1:0] i_opcode,
    input  logic                i_acc_neg,
    input  logic                i_mem_ready,
    output logic [CTRL_W-1:0]   o_control_signal,
    output logic                o_busy,
    output logic                o_halted,
    output logic                o_bus_error,
    output logic                o_illegal_op
);

    state_t      r_state;
    state_t      w_next;
    alu_sel_t    r_alu;
    alu_sel_t    w_alu_next;
    logic [CTRL_W-1:0] w_ctrl;
    logic        w_busy;
    logic        w_timer_clear;
    logic        w_timeout;

    // Wait states are never back-to-back, so clearing outside them
    // guarantees a zero count on every entry.
    assign w_timer_clear = !((r_state == ST_F_RD) ||
                             (r_state == ST_X_RD) ||
                             (r_state == ST_S_WR));

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_timer_clear),
        .i_mem_ready (i_mem_ready),
        .o_timeout   (w_timeout)
    );

    // State, ALU selection and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_alu            <= ALU_PASS;
            o_control_signal <= '0;
            o_busy           <= 1'b0;
            o_halted         <= 1'b0;
            o_bus_error      <= 1'b0;
            o_illegal_op     <= 1'b0;
        end else begin
            r_state          <= w_next;
            r_alu            <= w_alu_next;
            o_control_signal <= w_ctrl;
            o_busy           <= w_busy;
            o_halted         <= (w_next == ST_HALT);
            o_bus_error      <= (w_next == ST_ERR);
            o_illegal_op     <= (w_next == ST_ILL);
        end
    end

    // Next-state logic; the ALU operation is latched in DEC so X_EX does
    // not depend on the opcode input staying stable.
    always_comb begin
        w_next     = r_state;
        w_alu_next = r_alu;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_F_PC;
            ST_F_PC:  w_next = ST_F_RD;
            ST_F_RD: begin
                if (i_mem_ready)    w_next = ST_F_LAT;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_F_LAT: w_next = ST_F_IR;
            ST_F_IR:  w_next = ST_F_LD;
            ST_F_LD:  w_next = ST_DEC;
            ST_DEC: begin
                case (i_opcode)
                    OPCODE_W'(OP_STORE): w_next = ST_S_ACC;
                    OPCODE_W'(OP_LOAD): begin
                        w_next     = ST_X_RD;
                        w_alu_next = ALU_PASS;
                    end
                    OPCODE_W'(OP_ADD): begin
                        w_next     = ST_X_RD;
                        w_alu_next = ALU_ADD;
                    end
                    OPCODE_W'(OP_SUB): begin
                        w_next     = ST_X_RD;
                        w_alu_next = ALU_SUB;
                    end
                    OPCODE_W'(OP_JMPGEZ): w_next = i_acc_neg ? ST_F_PC : ST_J_PC;
                    OPCODE_W'(OP_JMP):    w_next = ST_J_PC;
                    OPCODE_W'(OP_HALT):   w_next = ST_HALT;
                    default:              w_next = ST_ILL;
                endcase
            end
            ST_S_ACC: w_next = ST_S_OUT;
            ST_S_OUT: w_next = ST_S_WR;
            ST_S_WR: begin
                if (i_mem_ready)    w_next = ST_F_PC;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_X_RD: begin
                if (i_mem_ready)    w_next = ST_X_LAT;
                else if (w_timeout) w_next = ST_ERR;
            end
            ST_X_LAT: w_next = ST_X_BR;
            ST_X_BR:  w_next = ST_X_EX;
            ST_X_EX:  w_next = ST_F_PC;
            ST_J_PC:  w_next = ST_J_LD;
            ST_J_LD:  w_next = ST_F_PC;
            ST_ILL:   w_next = ST_F_PC;
            ST_HALT:  w_next = ST_HALT;
            ST_ERR:   w_next = ST_ERR;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Control word and busy decoded from the state about to be entered
    always_comb begin
        w_ctrl = '0;
        w_busy = 1'b1;
        case (w_next)
            ST_IDLE, ST_HALT, ST_ERR: w_busy = 1'b0;
            ST_F_PC:  w_ctrl[CB_PC_TO_MAR] = 1'b1;
            ST_F_RD, ST_X_RD: w_ctrl[CB_MEM_RD] = 1'b1;
            ST_F_LAT: begin
                w_ctrl[CB_MEM_TO_MBR] = 1'b1;
                w_ctrl[CB_PC_INC]     = 1'b1;
            end
            ST_F_IR: begin
                w_ctrl[CB_MBR_TO_IR]  = 1'b1;
                w_ctrl[CB_MBR_TO_MAR] = 1'b1;
            end
            ST_F_LD: begin
                w_ctrl[CB_IR_LOAD]  = 1'b1;
                w_ctrl[CB_MAR_LOAD] = 1'b1;
            end
            ST_S_ACC: w_ctrl[CB_ACC_TO_MBR] = 1'b1;
            ST_S_OUT: w_ctrl[CB_MBR_TO_MEM] = 1'b1;
            ST_S_WR:  w_ctrl[CB_MEM_WR]     = 1'b1;
            ST_X_LAT: w_ctrl[CB_MEM_TO_MBR] = 1'b1;
            ST_X_BR:  w_ctrl[CB_MBR_TO_BR]  = 1'b1;
            ST_X_EX: begin
                case (w_alu_next)
                    ALU_ADD: w_ctrl[CB_ALU_ADD]   = 1'b1;
                    ALU_SUB: w_ctrl[CB_ALU_SUB]   = 1'b1;
                    default: w_ctrl[CB_BR_TO_ACC] = 1'b1;
                endcase
            end
            ST_J_PC:  w_ctrl[CB_MBR_TO_PC] = 1'b1;
            ST_J_LD:  w_ctrl[CB_PC_LOAD]   = 1'b1;
            default:  w_ctrl = '0;
        endcase
    end

endmodule : cpu_sequencer
`default_nettype wire
